// File: rtl/dft_pkg.sv
// Shared constants for the DFT dump collector: default sizing and the
// collector FSM state encoding.
package dft_pkg;

    localparam int DEPTH_DEFAULT      = 16;
    localparam int DUMP_WORDS_DEFAULT = 1;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [STATE_W-1:0] ST_COLLECT = 2'd1;
    localparam logic [STATE_W-1:0] ST_DRAIN   = 2'd2;
    localparam logic [STATE_W-1:0] ST_ACK     = 2'd3;

endpackage

// File: rtl/dft_sync_fifo.sv
// Single-clock first-word-fall-through FIFO of 32-bit words. A push while
// full is accepted only if a pop happens on the same edge; the freed head
// slot is the slot the write pointer already addresses.
module dft_sync_fifo
    import dft_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [31:0]            wr_data,
    input  logic                   pop,
    output logic [31:0]            rd_data,
    output logic                   rd_valid,
    output logic                   full,
    output logic [$clog2(DEPTH):0] fill
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign rd_valid = (fill != '0);
    assign full     = (fill == FULL_LVL);
    assign do_pop   = pop && rd_valid;
    assign do_push  = push && (!full || do_pop);

    // Head word is forced to zero while empty so the output never shows
    // stale or uninitialised storage.
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    // Storage write on accepted push.
    // NOTE: the storage array has no reset; contents are only observable
    // through rd_data, which is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers advance modulo DEPTH; fill tracks push/pop exactly.
    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   fill <= fill + (AW+1)'(1);
                2'b01:   fill <= fill - (AW+1)'(1);
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: rtl/dft_dump_collector.sv
// Collects strobed scan-dump words from the DFT stage into a FIFO for the
// host, counts words per dump and acknowledges the DFT stage's commit only
// once a complete dump has been fully drained by the host.
module dft_dump_collector
    import dft_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEFAULT,
    parameter int DUMP_WORDS = DUMP_WORDS_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            dft_out,
    input  logic                   dft_out_strobe,
    input  logic                   dft_op_commit,
    output logic                   dft_commit_ack,
    output logic [31:0]            rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [$clog2(DEPTH):0] fill,
    output logic [7:0]             dump_cnt,
    output logic                   overflow,
    input  logic                   clr_ovf
);

    localparam logic [7:0] LAST_WORD = 8'(DUMP_WORDS - 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [7:0]         word_cnt;
    logic               dump_done;
    logic               pend_done;
    logic               fifo_full;
    logic               pop_fire;
    logic               drop;
    logic               in_tail;

    dft_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (dft_out_strobe),
        .wr_data  (dft_out),
        .pop      (rd_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (fifo_full),
        .fill     (fill)
    );

    assign pop_fire       = rd_valid && rd_ready;
    assign drop           = dft_out_strobe && fifo_full && !pop_fire;
    assign dump_done      = dft_out_strobe && (word_cnt == LAST_WORD);
    assign in_tail        = (state == ST_DRAIN) || (state == ST_ACK);
    assign dft_commit_ack = (state == ST_ACK);

    // Next-state logic for the dump handshake.
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pend_done || dump_done) begin
                    state_nxt = ST_DRAIN;
                end else if (dft_out_strobe || (word_cnt != 8'd0)) begin
                    state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (dump_done) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((fill == '0) && dft_op_commit) state_nxt = ST_ACK;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register and completed-dump counter (wraps 255->0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            dump_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == ST_ACK) dump_cnt <= dump_cnt + 8'd1;
        end
    end

    // Word counter: every strobe counts, accepted or dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_cnt <= 8'd0;
        end else if (dft_out_strobe) begin
            word_cnt <= dump_done ? 8'd0 : word_cnt + 8'd1;
        end
    end

    // Remembers a dump completed while the previous one was still being
    // drained/acknowledged, so IDLE can go straight back to DRAIN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_done <= 1'b0;
        end else if ((state == ST_IDLE) && pend_done) begin
            pend_done <= dump_done;
        end else if (dump_done && in_tail) begin
            pend_done <= 1'b1;
        end
    end

    // Sticky overflow; a drop in the same cycle wins over the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dft_dump_collector.sv
// Self-checking bench for dft_dump_collector. Two instances share clock and
// reset: index 0 uses DUMP_WORDS=1, index 1 uses DUMP_WORDS=4. Only one
// instance is stimulated at a time, so a single scoreboard queue serves both.
module tb_dft_dump_collector;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [1:0]       strobe;
    logic [1:0]       rd_ready;
    logic [1:0]       commit;
    logic [1:0]       clr_ovf;
    logic [1:0][31:0] dout;
    logic [1:0]       rd_valid;
    logic [1:0]       ack;
    logic [1:0]       ovf;
    logic [1:0][31:0] rd_data;
    logic [1:0][4:0]  fill;
    logic [1:0][7:0]  dump_cnt;

    dft_dump_collector #(.DEPTH(DEPTH), .DUMP_WORDS(1)) u_dut1 (
        .clk            (clk),
        .reset          (reset),
        .dft_out        (dout[0]),
        .dft_out_strobe (strobe[0]),
        .dft_op_commit  (commit[0]),
        .dft_commit_ack (ack[0]),
        .rd_data        (rd_data[0]),
        .rd_valid       (rd_valid[0]),
        .rd_ready       (rd_ready[0]),
        .fill           (fill[0]),
        .dump_cnt       (dump_cnt[0]),
        .overflow       (ovf[0]),
        .clr_ovf        (clr_ovf[0])
    );

    dft_dump_collector #(.DEPTH(DEPTH), .DUMP_WORDS(4)) u_dut4 (
        .clk            (clk),
        .reset          (reset),
        .dft_out        (dout[1]),
        .dft_out_strobe (strobe[1]),
        .dft_op_commit  (commit[1]),
        .dft_commit_ack (ack[1]),
        .rd_data        (rd_data[1]),
        .rd_valid       (rd_valid[1]),
        .rd_ready       (rd_ready[1]),
        .fill           (fill[1]),
        .dump_cnt       (dump_cnt[1]),
        .overflow       (ovf[1]),
        .clr_ovf        (clr_ovf[1])
    );

    typedef struct {
        logic        strobe;
        logic [31:0] data;
        logic        rd_ready;
        logic        clr;
        logic [4:0]  exp_fill;
        logic        exp_ovf;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] sb[$];
    vec_t        vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus on instance k. Pops are compared against the
    // scoreboard before the edge; fill/rd_valid after it.
    task automatic step(input int k, input logic s, input logic [31:0] d,
                        input logic rr, input logic cm, input logic clr);
        logic full_m;
        logic pop_m;
        strobe   = '0;
        rd_ready = '0;
        commit   = '0;
        clr_ovf  = '0;
        dout     = '0;
        strobe[k]   = s;
        dout[k]     = d;
        rd_ready[k] = rr;
        commit[k]   = cm;
        clr_ovf[k]  = clr;
        #1;
        full_m = (sb.size() == DEPTH);
        pop_m  = rr && (sb.size() != 0);
        if (pop_m) begin
            check("pop_valid", 32'(rd_valid[k]), 32'd1);
            check("pop_data", rd_data[k], sb.pop_front());
        end
        if (s && (!full_m || pop_m)) sb.push_back(d);
        @(posedge clk);
        #1;
        check("fill", 32'(fill[k]), 32'(sb.size()));
        check("rd_valid", 32'(rd_valid[k]), 32'(sb.size() != 0));
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        strobe   = '0;
        rd_ready = '0;
        commit   = '0;
        clr_ovf  = '0;
        dout     = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_fill", 32'(fill[k]), 32'd0);
            check("rst_rd_valid", 32'(rd_valid[k]), 32'd0);
            check("rst_rd_data", rd_data[k], 32'd0);
            check("rst_dump_cnt", 32'(dump_cnt[k]), 32'd0);
            check("rst_overflow", 32'(ovf[k]), 32'd0);
            check("rst_ack", 32'(ack[k]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One DUMP_WORDS=1 dump with commit held: strobe, pop, ack, return.
    task automatic run_dump(output logic got);
        got = 1'b0;
        step(0, 1'b1, $urandom, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8 && !got; i++) begin
            step(0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
            if (ack[0]) got = 1'b1;
        end
        step(0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        int   acks;
        int   ack_at;
        int   zero_at;
        logic got;

        // Overflow / full-boundary table for the DUMP_WORDS=1 instance.
        for (int i = 0; i < 16; i++)
            vecs.push_back('{1'b1, 32'h1000_0000 + 32'(i), 1'b0, 1'b0, 5'(i + 1), 1'b0});
        vecs.push_back('{1'b1, 32'hBAD0_0017, 1'b0, 1'b0, 5'd16, 1'b1}); // 17th word lost
        vecs.push_back('{1'b1, 32'hBAD0_0018, 1'b0, 1'b1, 5'd16, 1'b1}); // drop beats clear
        vecs.push_back('{1'b0, 32'h0,         1'b0, 1'b1, 5'd16, 1'b0}); // clear alone
        vecs.push_back('{1'b1, 32'h2000_0034, 1'b1, 1'b0, 5'd16, 1'b0}); // push+pop at full
        for (int i = 0; i < 16; i++)
            vecs.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 5'(15 - i), 1'b0});

        do_reset();

        // Single-word dump, host ready, commit raised the cycle after strobe.
        step(0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        check("fwft_data", rd_data[0], 32'hDEAD_BEEF);
        acks   = 0;
        ack_at = -1;
        for (int i = 1; i <= 8; i++) begin
            step(0, 1'b0, 32'd0, 1'b1, logic'(acks == 0), 1'b0);
            if (ack[0]) begin
                acks++;
                if (ack_at < 0) ack_at = i;
            end
        end
        check("single_ack_count", 32'(acks), 32'd1);
        check("single_ack_cycle", 32'(ack_at), 32'd2);
        check("single_dump_cnt", 32'(dump_cnt[0]), 32'd1);

        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            step(0, vecs[i].strobe, vecs[i].data, vecs[i].rd_ready, 1'b0, vecs[i].clr);
            check($sformatf("vec%0d_fill", i), 32'(fill[0]), 32'(vecs[i].exp_fill));
            check($sformatf("vec%0d_ovf", i), 32'(ovf[0]), 32'(vecs[i].exp_ovf));
        end

        do_reset();

        // Four-word dump, commit held throughout, host stalled then ready.
        for (int i = 0; i < 4; i++) begin
            step(1, 1'b1, 32'h4000_0000 + 32'(i), 1'b0, 1'b1, 1'b0);
            check("collect_no_ack", 32'(ack[1]), 32'd0);
        end
        repeat (5) begin
            step(1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
            check("stalled_no_ack", 32'(ack[1]), 32'd0);
        end
        acks    = 0;
        ack_at  = -1;
        zero_at = -1;
        for (int i = 0; i < 12; i++) begin
            step(1, 1'b0, 32'd0, 1'b1, logic'(acks == 0), 1'b0);
            if (fill[1] == 5'd0 && zero_at < 0) zero_at = i;
            if (ack[1]) begin
                acks++;
                if (ack_at < 0) ack_at = i;
            end
        end
        check("drain_zero_cycle", 32'(zero_at), 32'd3);
        check("drain_ack_cycle", 32'(ack_at), 32'd4);
        check("drain_ack_count", 32'(acks), 32'd1);
        check("drain_dump_cnt", 32'(dump_cnt[1]), 32'd1);

        do_reset();

        // Reset while draining three words with commit pending.
        for (int i = 0; i < 3; i++)
            step(0, 1'b1, 32'h5000_0000 + 32'(i), 1'b0, 1'b1, 1'b0);
        check("pre_rst_ack", 32'(ack[0]), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_fill", 32'(fill[0]), 32'd0);
        check("async_rst_valid", 32'(rd_valid[0]), 32'd0);
        check("async_rst_data", rd_data[0], 32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
            if (ack[0]) acks++;
        end
        check("post_rst_no_ack", 32'(acks), 32'd0);
        check("post_rst_dump_cnt", 32'(dump_cnt[0]), 32'd0);

        do_reset();

        // 256 complete dumps: the counter wraps back to zero.
        for (int n = 0; n < 256; n++) begin
            run_dump(got);
            check($sformatf("dump%0d_ack", n), 32'(got), 32'd1);
            check($sformatf("dump%0d_cnt", n), 32'(dump_cnt[0]), 32'((n + 1) % 256));
        end
        check("dump_cnt_wrap", 32'(dump_cnt[0]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
